irq_ctrl: RTL

Bus-mapped interrupt controller that schedules the system interrupt lines (timer, and future peripherals) toward the CPU. It sits on the memory bus as a slave, typically selected at chip-select 11 (0xB000). It latches and masks the sources, then presents a single prioritized request to the CPU. Software claims the winning source and later signals end-of-interrupt (EOI); one interrupt is in service at a time.

---
 rtl/irq_ctrl_pkg.sv | 24 ++
 rtl/irq_ctrl_if.sv | 15 +
 rtl/irq_prio_enc.sv | 21 ++
 rtl/irq_ctrl.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/irq_ctrl_pkg.sv
// Shared definitions for the interrupt controller: register offsets,
// FSM state encoding and the default chip-select slot on the memory bus.
// No ports; imported by irq_ctrl and its sub-blocks.
package irq_ctrl_pkg;

  // Register offsets (bus_address[2:0])
  localparam logic [2:0] IC_PEND  = 3'd0;
  localparam logic [2:0] IC_MASK  = 3'd1;
  localparam logic [2:0] IC_EDGE  = 3'd2;
  localparam logic [2:0] IC_CUR   = 3'd3;
  localparam logic [2:0] IC_EOI   = 3'd4;
  localparam logic [2:0] IC_SWSET = 3'd5;
  localparam logic [2:0] IC_STAT  = 3'd6;

  // Address decoder slot the controller normally occupies (0xB000)
  localparam int IC_DEFAULT_CS = 11;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PENDING = 2'd1,
    ST_SERVICE = 2'd2
  } irq_state_t;

endpackage

// File: rtl/irq_ctrl_if.sv
// Memory-bus slave port of the interrupt controller.
// Signals: cs (select), wen (write enable), addr (offset), din (write data),
// dout (combinational read data). master = CPU/decoder side, slave = controller.
interface irq_ctrl_if #(
  parameter int WIDTH = 32
);
  logic             cs;
  logic             wen;
  logic [2:0]       addr;
  logic [WIDTH-1:0] din;
  logic [WIDTH-1:0] dout;

  modport master (output cs, output wen, output addr, output din, input dout);
  modport slave  (input cs, input wen, input addr, input din, output dout);
endinterface

// File: rtl/irq_prio_enc.sv
// Fixed-priority encoder: lowest set index wins.
// Latency: purely combinational. Backpressure: none.
// Ports: req_i (request vector), any_o (some bit set), id_o (winning index).
module irq_prio_enc #(
  parameter int NIRQ = 32
) (
  input  logic [NIRQ-1:0] req_i,
  output logic            any_o,
  output logic [4:0]      id_o
);

  always_comb begin
    any_o = |req_i;
    id_o  = '0;
    // Scan from the top so the lowest set index is the last one assigned.
    for (int i = NIRQ - 1; i >= 0; i--) begin
      if (req_i[i]) id_o = 5'(i);
    end
  end

endmodule

// File: rtl/irq_ctrl.sv
// Bus-mapped interrupt controller: latches/masks sources, raises one
// prioritized request, tracks a single in-service source via CLAIM/EOI.
// Latency: source edge to irq_o = 2 (sync, SYNC=1) + 1 (pend) + 1 (irq reg).
// Backpressure: none; bus accesses complete in the cycle cs is high.
// Ports: clk, reset (async, active-high), bus (slave modport),
// irq_in_i (raw sources), irq_o (request to CPU), cur_id_o (in-service ID).
module irq_ctrl
  import irq_ctrl_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int NIRQ  = 32,
  parameter int SYNC  = 1
) (
  input  logic            clk,
  input  logic            reset,
  irq_ctrl_if.slave       bus,
  input  logic [NIRQ-1:0] irq_in_i,
  output logic            irq_o,
  output logic [4:0]      cur_id_o
);

  logic [NIRQ-1:0] s;
  logic [NIRQ-1:0] prev_q;
  logic [NIRQ-1:0] pend_q, pend_d;
  logic [NIRQ-1:0] mask_q, mask_d;
  logic [NIRQ-1:0] edge_q, edge_d;
  logic [NIRQ-1:0] elig, win_oh, edge_rise, set_v, clr_v, wdat;
  logic            any;
  logic [4:0]      win_id;
  logic            wr, wr_pend, wr_mask, wr_edge, wr_cur, wr_eoi, wr_swset;
  logic            claim_ok;
  irq_state_t      state_q;
  logic            irq_q;
  logic            cur_valid_q;
  logic [4:0]      cur_id_q;
  logic [WIDTH-1:0] rdat;

  // ---------------- source synchronizer ----------------
  generate
    if (SYNC != 0) begin : g_sync
      logic [NIRQ-1:0] sync1_q, sync2_q;
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          sync1_q <= '0;
          sync2_q <= '0;
        end else begin
          sync1_q <= irq_in_i;
          sync2_q <= sync1_q;
        end
      end
      assign s = sync2_q;
    end else begin : g_nosync
      assign s = irq_in_i;
    end
  endgenerate

  // ---------------- bus write decode ----------------
  assign wr       = bus.cs & bus.wen;
  assign wdat     = bus.din[NIRQ-1:0];
  assign wr_pend  = wr && (bus.addr == IC_PEND);
  assign wr_mask  = wr && (bus.addr == IC_MASK);
  assign wr_edge  = wr && (bus.addr == IC_EDGE);
  assign wr_cur   = wr && (bus.addr == IC_CUR);
  assign wr_eoi   = wr && (bus.addr == IC_EOI);
  assign wr_swset = wr && (bus.addr == IC_SWSET);

  // ---------------- arbitration ----------------
  assign elig = pend_q & mask_q;

  irq_prio_enc #(.NIRQ(NIRQ)) u_prio (
    .req_i (elig),
    .any_o (any),
    .id_o  (win_id)
  );

  assign win_oh   = any ? (NIRQ'(1) << win_id) : '0;
  assign claim_ok = wr_cur && (state_q == ST_PENDING) && any;

  // ---------------- pending / mask / edge next state ----------------
  assign edge_rise = edge_q & s & ~prev_q;
  assign set_v     = edge_rise | (wr_swset ? (wdat & edge_q) : '0);
  assign clr_v     = (wr_pend ? wdat : '0) | (claim_ok ? win_oh : '0);

  // Edge bits: clear first, then OR in sets so a same-cycle set wins.
  // Level bits simply mirror the synchronized input.
  assign pend_d = (edge_q & ((pend_q & ~clr_v) | set_v)) | (~edge_q & s);
  assign mask_d = wr_mask ? wdat : mask_q;
  assign edge_d = wr_edge ? wdat : edge_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_q <= '0;
      pend_q <= '0;
      mask_q <= '0;
      edge_q <= '0;
    end else begin
      prev_q <= s;
      pend_q <= pend_d;
      mask_q <= mask_d;
      edge_q <= edge_d;
    end
  end

  // ---------------- service FSM ----------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      irq_q       <= 1'b0;
      cur_valid_q <= 1'b0;
      cur_id_q    <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (any) begin
            state_q <= ST_PENDING;
            irq_q   <= 1'b1;
          end
        end
        ST_PENDING: begin
          // Losing all eligible sources takes precedence over a CLAIM.
          if (!any) begin
            state_q <= ST_IDLE;
            irq_q   <= 1'b0;
          end else if (wr_cur) begin
            state_q     <= ST_SERVICE;
            irq_q       <= 1'b0;
            cur_valid_q <= 1'b1;
            cur_id_q    <= win_id;
          end
        end
        ST_SERVICE: begin
          // cur_id_q is kept for debug after EOI; only valid drops.
          if (wr_eoi) begin
            state_q     <= ST_IDLE;
            cur_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          irq_q   <= 1'b0;
        end
      endcase
    end
  end

  assign irq_o    = irq_q;
  assign cur_id_o = cur_id_q;

  // ---------------- read mux ----------------
  always_comb begin
    rdat = '0;
    if (bus.cs) begin
      case (bus.addr)
        IC_PEND:  rdat = WIDTH'(pend_q);
        IC_MASK:  rdat = WIDTH'(mask_q);
        IC_EDGE:  rdat = WIDTH'(edge_q);
        IC_CUR: begin
          rdat[31]  = cur_valid_q;
          rdat[4:0] = cur_id_q;
        end
        IC_SWSET: rdat = WIDTH'(s);
        IC_STAT:  rdat[1:0] = state_q;
        default:  rdat = '0;
      endcase
    end
  end

  assign bus.dout = rdat;

endmodule
